// File: rtl/otp_pkg.sv
// Types and constants shared by the one-time-pad encryptor and decryptor.
package otp_pkg;

    localparam int OTP_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        DECRYPT   = 2'd2,
        EXHAUSTED = 2'd3
    } otp_state_e;

endpackage

// File: rtl/otp_pad_mem.sv
// Pad storage: one synchronous write port, one combinational read port, no reset.
module otp_pad_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] words [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_W-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == AW'(gi))) begin
                    word_reg <= wr_data;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rd_data = words[rd_addr];

endmodule

// File: rtl/otp_decryptor.sv
// One-time-pad decryptor: XORs each ciphertext byte with the next unused pad byte.
// Build option: define OTP_CHECKSUM_EN for a running XOR checksum of emitted plaintext.
module otp_decryptor
    import otp_pkg::*;
#(
    parameter int PAD_DEPTH = 16,
    parameter int DATA_W    = OTP_DATA_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic                           key_start,
    input  logic                           key_valid,
    input  logic [DATA_W-1:0]              key_data,
    input  logic                           key_done,
    input  logic                           ct_valid,
    input  logic [DATA_W-1:0]              ct_data,
    output logic                           ct_ready,
    output logic                           pt_valid,
    output logic [DATA_W-1:0]              pt_data,
    input  logic                           pt_ready,
    output logic [$clog2(PAD_DEPTH+1)-1:0] pad_level,
    output logic                           pad_exhausted,
    output logic                           busy,
    output logic [DATA_W-1:0]              checksum
);

    localparam int AW = $clog2(PAD_DEPTH);
    localparam int CW = $clog2(PAD_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(PAD_DEPTH);

    otp_state_e        state_reg, state_next;
    logic [CW-1:0]     wr_cnt_reg, wr_cnt_next;
    logic [CW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic              pt_valid_reg, pt_valid_next;
    logic [DATA_W-1:0] pt_data_reg, pt_data_next;
    logic              pad_wr_en;
    logic              accept;
    logic [DATA_W-1:0] pad_rd_data;
    logic [DATA_W-1:0] plain;

    otp_pad_mem #(
        .DEPTH  (PAD_DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_pad_mem (
        .clk     (clk),
        .wr_en   (pad_wr_en),
        .wr_addr (wr_cnt_reg[AW-1:0]),
        .wr_data (key_data),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (pad_rd_data)
    );

    assign pad_level     = wr_cnt_reg - rd_ptr_reg;
    assign plain         = ct_data ^ pad_rd_data;
    // The output slot counts as free in the same cycle it drains.
    assign ct_ready      = ena && (state_reg == DECRYPT) && (pad_level != '0)
                           && (!pt_valid_reg || pt_ready);
    assign accept        = ct_valid && ct_ready;
    assign pt_valid      = pt_valid_reg;
    assign pt_data       = pt_data_reg;
    assign pad_exhausted = (state_reg == EXHAUSTED);
    assign busy          = (state_reg == LOAD) || (state_reg == DECRYPT);

    always_comb begin
        state_next    = state_reg;
        wr_cnt_next   = wr_cnt_reg;
        rd_ptr_next   = rd_ptr_reg;
        pt_valid_next = pt_valid_reg;
        pt_data_next  = pt_data_reg;
        pad_wr_en     = 1'b0;
        if (ena) begin
            if (pt_valid_reg && pt_ready) begin
                pt_valid_next = 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (key_start) begin
                        state_next  = LOAD;
                        wr_cnt_next = '0;
                        rd_ptr_next = '0;
                    end
                end
                LOAD: begin
                    if (key_valid) begin
                        pad_wr_en   = 1'b1;
                        wr_cnt_next = wr_cnt_reg + CW'(1);
                    end
                    if ((key_valid && (wr_cnt_reg + CW'(1) == FULL)) ||
                        (key_done && (key_valid || (wr_cnt_reg != '0)))) begin
                        state_next = DECRYPT;
                    end
                end
                DECRYPT: begin
                    if (accept) begin
                        pt_valid_next = 1'b1;
                        pt_data_next  = plain;
                        rd_ptr_next   = rd_ptr_reg + CW'(1);
                        if (rd_ptr_reg + CW'(1) == wr_cnt_reg) begin
                            state_next = EXHAUSTED;
                        end
                    end
                end
                EXHAUSTED: begin
                    if (key_start && !pt_valid_reg) begin
                        state_next  = LOAD;
                        wr_cnt_next = '0;
                        rd_ptr_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_cnt_reg   <= '0;
            rd_ptr_reg   <= '0;
            pt_valid_reg <= 1'b0;
            pt_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            wr_cnt_reg   <= wr_cnt_next;
            rd_ptr_reg   <= rd_ptr_next;
            pt_valid_reg <= pt_valid_next;
            pt_data_reg  <= pt_data_next;
        end
    end

`ifdef OTP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg;
    logic              ck_clear;

    assign ck_clear = (state_next == LOAD) && (state_reg != LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_reg <= '0;
        end else if (ck_clear) begin
            checksum_reg <= '0;
        end else if (accept) begin
            checksum_reg <= checksum_reg ^ plain;
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_otp_decryptor.sv
// Self-checking bench for otp_decryptor against a queue-based pad model.
module tb_otp_decryptor;

    localparam int PAD_DEPTH = 16;
    localparam int LW = $clog2(PAD_DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst, ena, key_start, key_valid, key_done;
    logic [7:0]    key_data, ct_data, pt_data, checksum;
    logic          ct_valid, ct_ready, pt_valid, pt_ready;
    logic [LW-1:0] pad_level;
    logic          pad_exhausted, busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_pad[$];
    int         model_rd;
    logic [7:0] model_ck;

    always #5 clk = ~clk;

    otp_decryptor #(.PAD_DEPTH(PAD_DEPTH), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .key_start(key_start), .key_valid(key_valid), .key_data(key_data), .key_done(key_done),
        .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready),
        .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
        .pad_level(pad_level), .pad_exhausted(pad_exhausted), .busy(busy), .checksum(checksum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ena = 1'b1; key_start = 1'b0; key_valid = 1'b0; key_data = 8'h00; key_done = 1'b0;
        ct_valid = 1'b0; ct_data = 8'h00; pt_ready = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Loads model_pad from IDLE; optional key_done on the final byte.
    task automatic do_load(input bit use_done);
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int i = 0; i < model_pad.size(); i++) begin
            key_valid = 1'b1;
            key_data  = model_pad[i];
            key_done  = use_done && (i == model_pad.size() - 1);
            tick();
        end
        key_valid = 1'b0;
        key_done  = 1'b0;
        model_rd  = 0;
        model_ck  = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] exp_ck;
        apply_reset();
        ct_valid = 1'b1;
        #1;
        exp_ck = 8'h00;
        checks++; if (pt_valid !== 1'b0) begin errors++; $display("FAIL reset_pt_valid: got %b want 0", pt_valid); end
        checks++; if (pt_data !== 8'h00) begin errors++; $display("FAIL reset_pt_data: got %h want 00", pt_data); end
        checks++; if (ct_ready !== 1'b0) begin errors++; $display("FAIL reset_ct_ready: got %b want 0", ct_ready); end
        checks++; if (pad_level !== LW'(0)) begin errors++; $display("FAIL reset_pad_level: got %0d want 0", pad_level); end
        checks++; if (pad_exhausted !== 1'b0) begin errors++; $display("FAIL reset_exhausted: got %b want 0", pad_exhausted); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (checksum !== exp_ck) begin errors++; $display("FAIL reset_checksum: got %h want %h", checksum, exp_ck); end
        ct_valid = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [7:0] cts [4];
        cts[0] = 8'h10; cts[1] = 8'h20; cts[2] = 8'h30; cts[3] = 8'h40;
        apply_reset();
        model_pad = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(1'b1);
        checks++; if (busy !== 1'b1 || pad_level !== LW'(4)) begin errors++; $display("FAIL basic_loaded: busy=%b level=%0d want busy=1 level=4", busy, pad_level); end
        checks++; if (pt_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid: got %b want 0", pt_valid); end
        pt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ct_valid = 1'b1;
            ct_data  = cts[i];
            #1;
            checks++; if (ct_ready !== 1'b1) begin errors++; $display("FAIL basic_ct_ready[%0d]: got %b want 1", i, ct_ready); end
            tick();
            checks++; if (pt_valid !== 1'b1 || pt_data !== (cts[i] ^ model_pad[i])) begin
                errors++; $display("FAIL basic_pt[%0d]: valid=%b data=%h want valid=1 data=%h", i, pt_valid, pt_data, cts[i] ^ model_pad[i]);
            end
            $display("basic ct=%h pt=%h", cts[i], pt_data);
        end
        #1;
        checks++; if (pad_exhausted !== 1'b1 || pad_level !== LW'(0)) begin errors++; $display("FAIL basic_exhausted: exh=%b level=%0d want 1/0", pad_exhausted, pad_level); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (ct_ready !== 1'b0) begin errors++; $display("FAIL basic_ct_ready_after[%0d]: got %b want 0", i, ct_ready); end
            tick();
        end
        checks++; if (pt_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", pt_valid); end
        ct_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        model_pad = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_load(1'b1);
        pt_ready = 1'b1; ct_valid = 1'b1; ct_data = 8'hAA;
        tick();
        pt_ready = 1'b0; ct_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pt_valid !== 1'b1 || pt_data !== 8'h55 || ct_ready !== 1'b0 || pad_level !== LW'(3)) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b level=%0d want 1/55/0/3", i, pt_valid, pt_data, ct_ready, pad_level);
            end
            tick();
        end
        pt_ready = 1'b1;
        #1;
        checks++; if (ct_ready !== 1'b1) begin errors++; $display("FAIL bp_handover_ready: got %b want 1", ct_ready); end
        tick();
        ct_valid = 1'b0;
        checks++; if (pt_valid !== 1'b1 || pt_data !== 8'h5A || pad_level !== LW'(2)) begin
            errors++; $display("FAIL bp_second: valid=%b data=%h level=%0d want 1/5a/2", pt_valid, pt_data, pad_level);
        end
        tick();
        checks++; if (pt_valid !== 1'b0 || pad_level !== LW'(2)) begin
            errors++; $display("FAIL bp_no_dup: valid=%b level=%0d want 0/2", pt_valid, pad_level);
        end
        $display("backpressure handover pt=5a");
    endtask

    task automatic test_full_pad_random();
        logic       exp_pv, exp_ready, exp_exh;
        logic [7:0] exp_pd, exp_ck;
        int         cyc;
        apply_reset();
        model_pad = {};
        for (int i = 0; i < PAD_DEPTH; i++) model_pad.push_back(8'($urandom));
        do_load(1'b0);
        checks++; if (busy !== 1'b1 || pad_exhausted !== 1'b0 || pad_level !== LW'(PAD_DEPTH)) begin
            errors++; $display("FAIL full_auto: busy=%b exh=%b level=%0d want 1/0/%0d", busy, pad_exhausted, pad_level, PAD_DEPTH);
        end
        exp_pv = 1'b0; exp_pd = 8'h00;
        cyc = 0;
        while ((model_rd < PAD_DEPTH || exp_pv) && cyc < 600) begin
            ct_valid = ($urandom_range(0, 3) != 0);
            ct_data  = 8'($urandom);
            pt_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = (model_rd < PAD_DEPTH) && (!exp_pv || pt_ready);
            checks++; if (ct_ready !== exp_ready) begin errors++; $display("FAIL rand_ct_ready[%0d]: got %b want %b", cyc, ct_ready, exp_ready); end
            tick();
            if (ct_valid && exp_ready) begin
                exp_pd = ct_data ^ model_pad[model_rd];
                exp_pv = 1'b1;
                model_ck = model_ck ^ exp_pd;
                model_rd++;
                $display("rand accept %0d ct=%h pt=%h", model_rd, ct_data, exp_pd);
            end else if (pt_ready) begin
                exp_pv = 1'b0;
            end
            exp_exh = (model_rd == PAD_DEPTH);
`ifdef OTP_CHECKSUM_EN
            exp_ck = model_ck;
`else
            exp_ck = 8'h00;
`endif
            checks++; if (pt_valid !== exp_pv || (exp_pv && pt_data !== exp_pd)) begin
                errors++; $display("FAIL rand_pt[%0d]: valid=%b data=%h want %b/%h", cyc, pt_valid, pt_data, exp_pv, exp_pd);
            end
            checks++; if (pad_level !== LW'(PAD_DEPTH - model_rd) || pad_exhausted !== exp_exh || busy !== !exp_exh) begin
                errors++; $display("FAIL rand_status[%0d]: level=%0d exh=%b busy=%b want %0d/%b/%b", cyc, pad_level, pad_exhausted, busy, PAD_DEPTH - model_rd, exp_exh, !exp_exh);
            end
            checks++; if (checksum !== exp_ck) begin errors++; $display("FAIL rand_checksum[%0d]: got %h want %h", cyc, checksum, exp_ck); end
            cyc++;
        end
        checks++; if (cyc >= 600) begin errors++; $display("FAIL rand_timeout: consumed %0d want %0d", model_rd, PAD_DEPTH); end
        ct_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        model_pad = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load(1'b1);
        pt_ready = 1'b1; ct_valid = 1'b1; ct_data = 8'h77;
        tick();
        tick();
        checks++; if (pt_valid !== 1'b1 || pad_level !== LW'(2)) begin errors++; $display("FAIL mid_pre: valid=%b level=%0d want 1/2", pt_valid, pad_level); end
        pt_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (pt_valid !== 1'b0 || busy !== 1'b0 || pad_level !== LW'(0) || ct_ready !== 1'b0 || pad_exhausted !== 1'b0) begin
                errors++; $display("FAIL mid_after[%0d]: valid=%b busy=%b level=%0d ready=%b exh=%b want 0/0/0/0/0", i, pt_valid, busy, pad_level, ct_ready, pad_exhausted);
            end
            tick();
        end
        ct_valid = 1'b0;
        $display("reset mid-decrypt done");
    endtask

    task automatic test_reload_ena();
        apply_reset();
        model_pad = '{8'h3C};
        do_load(1'b1);
        ct_valid = 1'b1; ct_data = 8'h00; pt_ready = 1'b0;
        tick();
        ct_valid = 1'b0;
        checks++; if (pad_exhausted !== 1'b1 || pt_valid !== 1'b1 || pt_data !== 8'h3C) begin
            errors++; $display("FAIL reload_exh: exh=%b valid=%b data=%h want 1/1/3c", pad_exhausted, pt_valid, pt_data);
        end
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        checks++; if (pad_exhausted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reload_ignored: exh=%b busy=%b want 1/0", pad_exhausted, busy); end
        pt_ready = 1'b1;
        tick();
        pt_ready = 1'b0;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        checks++; if (busy !== 1'b1 || pad_exhausted !== 1'b0 || pad_level !== LW'(0)) begin
            errors++; $display("FAIL reload_load: busy=%b exh=%b level=%0d want 1/0/0", busy, pad_exhausted, pad_level);
        end
        key_valid = 1'b1; key_data = 8'h0F;
        tick();
        key_data = 8'h5A; key_done = 1'b1;
        tick();
        key_valid = 1'b0; key_done = 1'b0;
        ct_valid = 1'b1; ct_data = 8'hF0;
        tick();
        checks++; if (pt_valid !== 1'b1 || pt_data !== 8'hFF) begin errors++; $display("FAIL reload_pt: valid=%b data=%h want 1/ff", pt_valid, pt_data); end
        ena = 1'b0; pt_ready = 1'b1; ct_data = 8'h33;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ct_ready !== 1'b0 || pt_valid !== 1'b1 || pt_data !== 8'hFF || pad_level !== LW'(1) || busy !== 1'b1) begin
                errors++; $display("FAIL ena_freeze[%0d]: ready=%b valid=%b data=%h level=%0d busy=%b want 0/1/ff/1/1", i, ct_ready, pt_valid, pt_data, pad_level, busy);
            end
            tick();
        end
        ena = 1'b1;
        #1;
        checks++; if (ct_ready !== 1'b1) begin errors++; $display("FAIL ena_resume_ready: got %b want 1", ct_ready); end
        tick();
        ct_valid = 1'b0;
        checks++; if (pt_valid !== 1'b1 || pt_data !== 8'h69 || pad_exhausted !== 1'b1) begin
            errors++; $display("FAIL ena_resume_pt: valid=%b data=%h exh=%b want 1/69/1", pt_valid, pt_data, pad_exhausted);
        end
        $display("reload pt=ff then pt=69");
    endtask

    task automatic test_checksum();
        logic [7:0] pts [3];
        logic [7:0] exp_ck;
        pts[0] = 8'h01; pts[1] = 8'h02; pts[2] = 8'h04;
        apply_reset();
        model_pad = {};
        for (int i = 0; i < 3; i++) model_pad.push_back(8'($urandom));
        do_load(1'b1);
        pt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ct_valid = 1'b1;
            ct_data  = model_pad[i] ^ pts[i];
            tick();
            model_ck = model_ck ^ pts[i];
            checks++; if (pt_data !== pts[i]) begin errors++; $display("FAIL ck_pt[%0d]: got %h want %h", i, pt_data, pts[i]); end
        end
        ct_valid = 1'b0;
`ifdef OTP_CHECKSUM_EN
        exp_ck = model_ck;
`else
        exp_ck = 8'h00;
`endif
        checks++; if (checksum !== exp_ck) begin errors++; $display("FAIL ck_value: got %h want %h", checksum, exp_ck); end
        tick();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        checks++; if (busy !== 1'b1 || checksum !== 8'h00) begin errors++; $display("FAIL ck_clear: busy=%b checksum=%h want 1/00", busy, checksum); end
        $display("checksum after 01,02,04 expected %h", exp_ck);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_basic();
        test_backpressure();
        test_full_pad_random();
        test_reset_mid();
        test_reload_ena();
        test_checksum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
